// File: rtl/piezo_tune_seq_if.sv
// Sequencer <-> control/piezo datapath bundle.
// master = sequencer side, slave = system control and duration counter side.
interface piezo_tune_seq_if;
  logic        start;
  logic        abort;
  logic        note_over;
  logic        dur_clr;
  logic        dur_en;
  logic [7:0]  note_dur;
  logic [14:0] note_per;
  logic        snd_en;
  logic        busy;
  logic        done;

  modport master (
    input  start,
    input  abort,
    input  note_over,
    output dur_clr,
    output dur_en,
    output note_dur,
    output note_per,
    output snd_en,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output note_over,
    input  dur_clr,
    input  dur_en,
    input  note_dur,
    input  note_per,
    input  snd_en,
    input  busy,
    input  done
  );
endinterface

// File: rtl/piezo_tune_seq.sv
// Four-note fanfare sequencer for the piezo path.
// Drives the shared duration counter for both notes and inter-note gaps.
module piezo_tune_seq #(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 2
) (
  input logic              clk,
  input logic              rst,
  piezo_tune_seq_if.master bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] GAP_DUR = 8'(GAP_TICKS);

  typedef enum logic [2:0] {
    IDLE, LOAD_N, PLAY, LOAD_G, GAP
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    idx;
  logic [PW-1:0] pre;
  logic          tick;
  logic          fin;
  logic          done_q;
  logic          timing;
  logic [14:0]   rom_per;
  logic [7:0]    rom_dur;

  always_comb begin
    rom_per = 15'd0;
    rom_dur = 8'd0;
    unique case (idx)
      2'd0: begin rom_per = 15'd31888; rom_dur = 8'd25; end
      2'd1: begin rom_per = 15'd23889; rom_dur = 8'd25; end
      2'd2: begin rom_per = 15'd18961; rom_dur = 8'd25; end
      2'd3: begin rom_per = 15'd15944; rom_dur = 8'd50; end
    endcase
  end

  assign timing = (state == PLAY) || (state == GAP);
  assign tick   = (pre == TICK_LAST);
  // abort wins over a coinciding note_over, so no done in that case
  assign fin    = (state == PLAY) && bus.note_over
                  && (idx == 2'd3) && !bus.abort;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= 2'd0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= fin;
      if (state_nxt == IDLE)
        idx <= 2'd0;
      else if (state == GAP && state_nxt == LOAD_N)
        idx <= idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pre <= '0;
    else if (timing && !tick)
      pre <= pre + 1'b1;
    else
      pre <= '0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (bus.start && !bus.abort) state_nxt = LOAD_N;
      LOAD_N:
        state_nxt = bus.abort ? IDLE : PLAY;
      PLAY:
        if (bus.abort)
          state_nxt = IDLE;
        else if (bus.note_over)
          state_nxt = (idx == 2'd3) ? IDLE : LOAD_G;
      LOAD_G:
        state_nxt = bus.abort ? IDLE : GAP;
      GAP:
        if (bus.abort)
          state_nxt = IDLE;
        else if (bus.note_over)
          state_nxt = LOAD_N;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.dur_clr  = 1'b0;
    bus.dur_en   = 1'b0;
    bus.note_dur = 8'd0;
    bus.note_per = 15'd0;
    bus.snd_en   = 1'b0;
    bus.busy     = (state != IDLE);
    bus.done     = done_q;
    unique case (state)
      IDLE: ;
      LOAD_N: begin
        bus.dur_clr  = 1'b1;
        bus.note_per = rom_per;
        bus.note_dur = rom_dur;
      end
      PLAY: begin
        bus.snd_en   = 1'b1;
        bus.dur_en   = tick;
        bus.note_per = rom_per;
        bus.note_dur = rom_dur;
      end
      LOAD_G: begin
        bus.dur_clr  = 1'b1;
        bus.note_dur = GAP_DUR;
      end
      GAP: begin
        bus.dur_en   = tick;
        bus.note_dur = GAP_DUR;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_piezo_tune_seq.sv
// Bench for piezo_tune_seq with a duration-counter model and a
// segment-based timeline model of the tune.
module tb_piezo_tune_seq;
  localparam int TD = 4;
  localparam int GT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  piezo_tune_seq_if bus();

  piezo_tune_seq #(
    .TICK_DIV (TD),
    .GAP_TICKS(GT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // duration counter of the piezo datapath
  logic [7:0] dcnt;
  always_ff @(posedge clk) begin
    if (rst || bus.dur_clr) dcnt <= 8'd0;
    else if (bus.dur_en)    dcnt <= dcnt + 8'd1;
  end
  assign bus.note_over = (dcnt == bus.note_dur);

  typedef struct packed {
    logic        busy;
    logic        snd;
    logic [14:0] per;
  } smp_t;

  int errors = 0;
  int checks = 0;
  int rom_per[4] = '{31888, 23889, 18961, 15944};
  int rom_dur[4] = '{25, 25, 25, 50};

  smp_t exp_q[$];
  smp_t obs_q[$];
  int   done_cnt;
  int   done_cyc;
  int   clash;
  bit   post_any;
  bit   tmo;

  function automatic void build_exp(input int cut);
    exp_q.delete();
    for (int n = 0; n < 4; n++) begin
      exp_q.push_back('{1'b1, 1'b0, 15'(rom_per[n])});
      repeat (rom_dur[n] * TD + 1)
        exp_q.push_back('{1'b1, 1'b1, 15'(rom_per[n])});
      if (n < 3)
        repeat (GT * TD + 2)
          exp_q.push_back('{1'b1, 1'b0, 15'd0});
    end
    if (cut > 0)
      while (exp_q.size() > cut) void'(exp_q.pop_back());
  endfunction

  function automatic int tl_diff();
    int d = (obs_q.size() > exp_q.size()) ?
            obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) d++;
    return d;
  endfunction

  function automatic void summarize(input smp_t q[$],
                                    output int pers[$],
                                    output int runs[$]);
    int r = 0;
    pers.delete();
    runs.delete();
    for (int i = 0; i < q.size(); i++) begin
      if (pers.size() == 0 || pers[$] != int'(q[i].per))
        pers.push_back(int'(q[i].per));
      if (q[i].snd) r++;
      else if (r > 0) begin runs.push_back(r); r = 0; end
    end
    if (r > 0) runs.push_back(r);
  endfunction

  function automatic int q_diff(input int a[$], input int b[$]);
    int d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] != b[i]) d++;
    return d;
  endfunction

  function automatic logic any_out();
    return bus.dur_clr | bus.dur_en | (|bus.note_dur) |
           (|bus.note_per) | bus.snd_en | bus.busy | bus.done;
  endfunction

  task automatic play(input int abort_at, input int rst_at,
                      input bit spam, input bit abort_last);
    int c;
    obs_q.delete();
    done_cnt = 0; done_cyc = 0; clash = 0; post_any = 0; tmo = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c = 1;
    forever begin
      if (bus.dur_en && bus.dur_clr) clash++;
      if (bus.done) begin done_cnt++; done_cyc = c; end
      if (!bus.busy) break;
      obs_q.push_back('{bus.busy, bus.snd_en, bus.note_per});
      bus.abort = (c == abort_at) ||
                  (abort_last && bus.snd_en && bus.note_over &&
                   bus.note_per == 15'd15944);
      rst = (c == rst_at);
      bus.start = spam && ($urandom_range(0, 3) == 0);
      if (c >= 2000) begin tmo = 1; break; end
      @(negedge clk);
      c++;
    end
    post_any = bus.dur_clr | bus.dur_en | (|bus.note_dur) |
               (|bus.note_per) | bus.snd_en | bus.busy;
    bus.abort = 1'b0;
    bus.start = 1'b0;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bus.done) begin done_cnt++; done_cyc = c + k; end
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.abort = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (any_out()) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_outputs: %0d active cycles, want 0", bad);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (any_out()) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_quiet: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_full_tune(input bit spam, input string tag);
    int op[$], or_[$], ep[$], er[$];
    play(0, 0, spam, 0);
    build_exp(0);
    summarize(obs_q, op, or_);
    summarize(exp_q, ep, er);
    checks++;
    if (tmo !== 1'b0 || obs_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", tag,
               obs_q.size(), exp_q.size());
    end
    checks++;
    if (tl_diff() !== 0) begin
      errors++;
      $display("FAIL %s timeline: %0d bad cycles, want 0", tag, tl_diff());
    end
    checks++;
    if (q_diff(op, ep) !== 0) begin
      errors++;
      $display("FAIL %s note_per_seq: got %p want %p", tag, op, ep);
    end
    checks++;
    if (q_diff(or_, er) !== 0) begin
      errors++;
      $display("FAIL %s snd_runs: got %p want %p", tag, or_, er);
    end
    checks++;
    if (done_cnt !== 1 || done_cyc !== exp_q.size() + 1) begin
      errors++;
      $display("FAIL %s done: %0d pulses at cycle %0d, want 1 at %0d",
               tag, done_cnt, done_cyc, exp_q.size() + 1);
    end
    checks++;
    if (clash !== 0 || post_any !== 1'b0) begin
      errors++;
      $display("FAIL %s clr_en_post: clash=%0d post=%0b want 0/0",
               tag, clash, post_any);
    end
  endtask

  task automatic check_cut(input int cut, input string tag);
    build_exp(cut);
    checks++;
    if (tmo !== 1'b0 || obs_q.size() !== cut) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", tag, obs_q.size(), cut);
    end
    checks++;
    if (tl_diff() !== 0) begin
      errors++;
      $display("FAIL %s timeline: %0d bad cycles, want 0", tag, tl_diff());
    end
    checks++;
    if (done_cnt !== 0 || post_any !== 1'b0) begin
      errors++;
      $display("FAIL %s stop: done=%0d post=%0b want 0/0",
               tag, done_cnt, post_any);
    end
  endtask

  task automatic test_abort_mid_note();
    int at = 1 + 101 + 10 + 1 + 40;
    play(at, 0, 0, 0);
    check_cut(at, "abort_note1");
    for (int i = 0; i < 3; i++) begin
      at = $urandom_range(1, 537);
      play(at, 0, 0, 0);
      check_cut(at, "abort_rand");
    end
    test_full_tune(0, "after_abort");
  endtask

  task automatic test_abort_last_over();
    play(0, 0, 0, 1);
    build_exp(0);
    check_cut(exp_q.size(), "abort_last");
  endtask

  task automatic test_rst_in_gap();
    int gaps[$];
    int at;
    build_exp(0);
    for (int i = 0; i < exp_q.size(); i++)
      if (!exp_q[i].snd && exp_q[i].per == 15'd0) gaps.push_back(i + 1);
    at = gaps[$urandom_range(0, gaps.size() - 1)];
    play(0, at, 0, 0);
    check_cut(at, "rst_gap");
    test_full_tune(0, "after_rst");
  endtask

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    test_reset();
    test_full_tune(0, "full");
    test_full_tune(1, "start_spam");
    test_abort_mid_note();
    test_abort_last_over();
    test_rst_in_gap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
